// File: rtl/riscv_core_muxnx1_pipe.sv
// N-input, XLEN-wide select mux feeding a two-entry skid buffer with valid/ready on both sides.
// Optional per-entry out-of-range select flag: define RISCV_CORE_MUXNX1_SELCHK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | no entry held; output invalid
// ST_ONE   | head entry in main register
// ST_FULL  | head in main, next entry in skid; upstream stalled
module riscv_core_muxnx1_pipe #(
    parameter int XLEN   = 64,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_IN*XLEN-1:0] i_muxnx1_in,
    input  logic [SEL_W-1:0]       i_muxnx1_sel,
    input  logic                   i_muxnx1_valid,
    output logic                   o_muxnx1_ready,
    input  logic                   i_muxnx1_flush,
    output logic [XLEN-1:0]        o_muxnx1_out,
    output logic                   o_muxnx1_valid,
    input  logic                   i_muxnx1_ready
`ifdef RISCV_CORE_MUXNX1_SELCHK_EN
    ,
    output logic                   o_muxnx1_selerr
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] main_data;
    logic [XLEN-1:0] skid_data;
    logic [XLEN-1:0] sel_data;
    logic            push;
    logic            pop;

    // Selects with no matching input leave sel_data at zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i_muxnx1_sel == SEL_W'(k)) begin
                sel_data = i_muxnx1_in[k*XLEN +: XLEN];
            end
        end
    end

    assign o_muxnx1_valid = (state != ST_EMPTY);
    assign o_muxnx1_ready = (state != ST_FULL) && !i_rst;
    assign o_muxnx1_out   = main_data;
    assign push           = i_muxnx1_valid && o_muxnx1_ready;
    assign pop            = o_muxnx1_valid && i_muxnx1_ready;

`ifdef RISCV_CORE_MUXNX1_SELCHK_EN
    logic sel_oor;
    logic main_err;
    logic skid_err;

    assign sel_oor         = (32'(i_muxnx1_sel) >= NUM_IN);
    assign o_muxnx1_selerr = main_err;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_muxnx1_flush) begin
            main_err <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: if (push) main_err <= sel_oor;
                ST_ONE: begin
                    if (push && !pop)     skid_err <= sel_oor;
                    else if (push && pop) main_err <= sel_oor;
                end
                ST_FULL:  if (pop) main_err <= skid_err;
                default:  main_err <= 1'b0;
            endcase
        end
    end

    assert property (@(posedge i_clk) disable iff (i_rst) push |-> !sel_oor);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (i_muxnx1_flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state     <= ST_ONE;
                        main_data <= sel_data;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state     <= ST_FULL;
                        skid_data <= sel_data;
                    end else if (pop && !push) begin
                        state <= ST_EMPTY;
                    end else if (push && pop) begin
                        main_data <= sel_data;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state     <= ST_ONE;
                        main_data <= skid_data;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule
